sram_req_ctrl: RTL and testbench

- Request/response front-end that sits directly upstream of the 2048x16 single-port SRAM wrapper and drives its ADR/D/WE/ME pins.
- Converts a valid/ready request stream into registered SRAM commands.
- Tracks the in-flight read pipeline and returns read data through a credit-protected response FIFO, so consumers may apply backpressure.
- After reset, optionally zero-fills the whole SRAM before accepting traffic.

---
 rtl/sram_req_ctrl_pkg.sv | 11 +
 rtl/sram_req_ctrl_rsp_fifo.sv | 62 ++++++
 rtl/sram_req_ctrl.sv | 118 +++++++++++
 tb/tb_sram_req_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_ctrl_pkg.sv
// Shared types and constants for the SRAM request controller.
package sram_ctrl_pkg;

  typedef enum logic {INIT, RUN} state_e;

  localparam int SRAM_AW = 11;
  localparam int SRAM_DW = 16;
  // Cycles from the accept decision to the edge that captures sram_q.
  localparam int RD_LAT  = 2;

endpackage

// File: rtl/sram_req_ctrl_rsp_fifo.sv
// Flop-based synchronous response FIFO with same-cycle push/pop.
module rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [PW-1:0]            wr_q, rd_q;
  logic [CW-1:0]            cnt_q;
  logic                     do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // A pop frees a slot in the same cycle, so a full FIFO may still take a push.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Upstream credit gating must make overflow impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready front-end for a single-port SRAM: optional zero-fill after
// reset, registered SRAM commands, and credit-protected read responses.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW        = SRAM_AW,
  parameter int DW        = SRAM_DW,
  parameter int RSP_DEPTH = 4,
  parameter bit INIT_EN   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          init_done,
  output logic [AW-1:0] sram_adr,
  output logic [DW-1:0] sram_d,
  output logic          sram_we,
  output logic          sram_me,
  input  logic [DW-1:0] sram_q
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [AW:0] INIT_LAST = {1'b0, {AW{1'b1}}};

  state_e            state_q;
  logic [AW:0]       init_cnt_q;
  logic              init_done_q;
  logic              me_q, we_q;
  logic [AW-1:0]     adr_q;
  logic [DW-1:0]     d_q;
  logic [RD_LAT-1:0] rd_pipe_q;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_full, fifo_empty;
  logic [CW:0]       inflight;
  logic              credit_ok, fire, push, pop;

  // Reads accepted but not yet captured into the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + (CW+1)'(rd_pipe_q[i]);
  end

  // Every accepted read must have a guaranteed FIFO slot when its data lands.
  assign credit_ok = !fifo_full && (({1'b0, fifo_cnt} + inflight) < (CW+1)'(RSP_DEPTH));
  // Held low while in reset; init_done keeps the first RUN cycle closed so
  // traffic starts only after the last init write has left the pins.
  assign req_ready = rst_n && (state_q == RUN) && init_done_q && credit_ok;
  assign fire      = req_valid && req_ready;
  assign push      = rd_pipe_q[RD_LAT-1];
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = !fifo_empty;

  assign init_done = init_done_q;
  assign sram_me   = me_q;
  assign sram_we   = we_q;
  assign sram_adr  = adr_q;
  assign sram_d    = d_q;

  // Controller FSM: zero-fill sweep, then one registered command per accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_EN ? INIT : RUN;
      init_cnt_q  <= '0;
      init_done_q <= !INIT_EN;
      me_q        <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      d_q         <= '0;
    end else begin
      case (state_q)
        INIT: begin
          me_q  <= 1'b1;
          we_q  <= 1'b1;
          d_q   <= '0;
          adr_q <= init_cnt_q[AW-1:0];
          if (init_cnt_q == INIT_LAST) state_q    <= RUN;
          else                         init_cnt_q <= init_cnt_q + 1'b1;
        end
        RUN: begin
          init_done_q <= 1'b1;
          me_q        <= fire;
          we_q        <= fire && req_we;
          if (fire) begin
            adr_q <= req_addr;
            d_q   <= req_wdata;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Read tracking: one bit per stage between accept and data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pipe_q <= '0;
    else        rd_pipe_q <= {rd_pipe_q[RD_LAT-2:0], fire && !req_we};
  end

  rsp_fifo #(.DEPTH(RSP_DEPTH), .DW(DW)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (sram_q),
    .pop_i   (pop),
    .data_o  (rsp_data),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: one instance with zero-fill, one without, each
// with a behavioural SRAM attached; responses checked against a memory/queue
// reference model.
module tb_sram_req_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n1, rst_n0;
  logic        req_valid, req_we, rsp_ready;
  logic [10:0] req_addr;
  logic [15:0] req_wdata;

  logic        rr1, rv1, id1, we1, me1, rr0, rv0, id0, we0, me0;
  logic [15:0] rd1, d1, q1, rd0, d0, q0;
  logic [10:0] adr1, adr0;

  sram_req_ctrl #(.AW(11), .DW(16), .RSP_DEPTH(4), .INIT_EN(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .req_valid(req_valid), .req_ready(rr1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1), .init_done(id1),
    .sram_adr(adr1), .sram_d(d1), .sram_we(we1), .sram_me(me1), .sram_q(q1));

  sram_req_ctrl #(.AW(11), .DW(16), .RSP_DEPTH(4), .INIT_EN(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n0), .req_valid(req_valid), .req_ready(rr0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_data(rd0), .init_done(id0),
    .sram_adr(adr0), .sram_d(d0), .sram_we(we0), .sram_me(me0), .sram_q(q0));

  // Behavioural single-port SRAMs: Q is valid the cycle after a read command.
  logic [15:0] mem1 [0:2047];
  logic [15:0] mem0 [0:2047];
  always @(posedge clk) if (me1) begin if (we1) mem1[adr1] = d1; else q1 <= mem1[adr1]; end
  always @(posedge clk) if (me0) begin if (we0) mem0[adr0] = d0; else q0 <= mem0[adr0]; end

  logic        sel;
  logic        rr_s, rv_s;
  logic [15:0] rd_s;
  assign rr_s = sel ? rr1 : rr0;
  assign rv_s = sel ? rv1 : rv0;
  assign rd_s = sel ? rd1 : rd0;

  typedef struct { logic [15:0] data; int cyc; } exp_t;
  typedef struct { bit we; logic [10:0] addr; logic [15:0] wdata; logic [15:0] exp; } vec_t;

  exp_t        exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] mem_ref [0:2047];
  vec_t        tbl[$];
  int tests = 0, fails = 0, cyc = 0, run_cur = 0, run_max = 0, last_pop = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One RUN-mode cycle: compare against the model, then advance the model.
  // Outstanding reads (accepted, not yet consumed) never exceed the FIFO depth,
  // and a read becomes visible three cycles after it was accepted.
  task automatic tick(output bit fired);
    bit ev;
    @(negedge clk);
    ev = (exp_q.size() > 0) && (exp_q[0].cyc + 3 <= cyc);
    chk("req_ready", rr_s, exp_q.size() < 4);
    chk("rsp_valid", rv_s, ev);
    if (ev && rv_s) chk("rsp_data", rd_s, exp_q[0].data);
    if (rv_s) run_cur++; else run_cur = 0;
    if (run_cur > run_max) run_max = run_cur;
    fired = req_valid && rr_s;
    if (rv_s && rsp_ready && exp_q.size() > 0) begin
      got_q.push_back(rd_s);
      last_pop = cyc;
      void'(exp_q.pop_front());
    end
    if (fired) begin
      if (req_we) mem_ref[req_addr] = req_wdata;
      else        exp_q.push_back('{data: mem_ref[req_addr], cyc: cyc});
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit f, f2;
    int e_pins, e_done, e_rdy, nf, e, j;
    rst_n1 = 1'b0; rst_n0 = 1'b0; sel = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      mem0[i]    = 16'(i) ^ 16'h5A5A;
      mem_ref[i] = 16'h0;
    end

    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_req_ready", rr1, 0);  chk("rst_rsp_valid", rv1, 0);
    chk("rst_rsp_data", rd1, 0);   chk("rst_sram_me", me1, 0);
    chk("rst_sram_we", we1, 0);    chk("rst_sram_adr", adr1, 0);
    chk("rst_sram_d", d1, 0);      chk("rst_init_done", id1, 0);
    chk("rst0_init_done", id0, 1); chk("rst0_req_ready", rr0, 0);

    // Zero-fill sweep
    @(posedge clk); #1; rst_n1 = 1'b1;
    e_pins = 0; e_done = 0; e_rdy = 0;
    for (int c = 0; c <= 2050; c++) begin
      bit on;
      @(negedge clk);
      on = (c >= 1) && (c <= 2048);
      if (me1 !== on || we1 !== on) e_pins++;
      if (on && (adr1 !== 11'(c - 1) || d1 !== 16'h0)) e_pins++;
      if (id1 !== (c >= 2049)) e_done++;
      if (rr1 !== (c >= 2049)) e_rdy++;
      if (c == 2048) chk("init_last_adr", adr1, 11'h7FF);
      if (c == 2049) chk("init_done_rise", id1, 1);
      @(posedge clk); #1;
    end
    chk("init_pin_errs", e_pins, 0);
    chk("init_done_errs", e_done, 0);
    chk("init_ready_errs", e_rdy, 0);
    cyc = 2051;

    // Directed table: RAW at the top address, bottom address, b2b reads, preloads
    tbl.push_back('{we: 1'b1, addr: 11'h7FF, wdata: 16'h1234, exp: 16'h0});
    tbl.push_back('{we: 1'b0, addr: 11'h7FF, wdata: 16'h0,    exp: 16'h1234});
    tbl.push_back('{we: 1'b0, addr: 11'h000, wdata: 16'h0,    exp: 16'h0000});
    for (int i = 0; i < 8; i++) tbl.push_back('{we: 1'b1, addr: 11'(i), wdata: 16'hA000 + 16'(i), exp: 16'h0});
    for (int i = 0; i < 4; i++) tbl.push_back('{we: 1'b1, addr: 11'h20 + 11'(i), wdata: 16'hB000 + 16'(i), exp: 16'h0});
    for (int i = 0; i < 8; i++) tbl.push_back('{we: 1'b0, addr: 11'(i), wdata: 16'h0, exp: 16'hA000 + 16'(i)});
    rsp_ready = 1'b1; got_q.delete(); run_max = 0;
    foreach (tbl[i]) begin
      req_valid = 1'b1; req_we = tbl[i].we; req_addr = tbl[i].addr; req_wdata = tbl[i].wdata;
      f = 1'b0;
      for (int k = 0; k < 10 && !f; k++) tick(f);
      chk("tbl_fire", f, 1);
    end
    req_valid = 1'b0;
    repeat (6) tick(f);
    chk("tbl_nreads", got_q.size(), 10);
    j = 0;
    foreach (tbl[i]) if (!tbl[i].we) begin
      if (j < got_q.size()) chk("tbl_rdata", got_q[j], tbl[i].exp);
      j++;
    end
    chk("b2b_valid_run", run_max >= 8, 1);

    // Backpressure: credits stop acceptance at four outstanding reads
    rsp_ready = 1'b0; req_we = 1'b0; nf = 0;
    for (int k = 0; k < 10; k++) begin
      req_valid = 1'b1; req_addr = 11'h20 + 11'(nf);
      tick(f);
      if (f) nf++;
    end
    chk("bp_accepted", nf, 4);
    chk("bp_ready_low", rr1, 0);
    chk("bp_rsp_held", rd1, 16'hB000);
    req_valid = 1'b0; rsp_ready = 1'b1; got_q.delete();
    repeat (8) tick(f);
    chk("bp_npops", got_q.size(), 4);
    foreach (got_q[i]) chk("bp_order", got_q[i], 16'hB000 + 16'(i));

    // Randomised traffic on a small address window to hit read-after-write
    for (int k = 0; k < 400; k++) begin
      req_valid = ($urandom_range(3, 0) != 0);
      req_we    = $urandom_range(1, 0) == 1;
      req_addr  = 11'($urandom_range(15, 0));
      req_wdata = 16'($urandom);
      rsp_ready = ($urandom_range(3, 0) != 0);
      tick(f);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (8) tick(f);
    chk("rand_drained", exp_q.size(), 0);

    // Reset with two reads in flight
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h3; tick(f);
    req_addr = 11'h4; tick(f2);
    req_valid = 1'b0;
    chk("mid_rst_fires", f && f2, 1);
    #2 rst_n1 = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rv1, 0);
    chk("mid_rst_sram_me", me1, 0);
    chk("mid_rst_req_ready", rr1, 0);
    repeat (2) @(posedge clk); #1;
    rst_n1 = 1'b1; exp_q.delete();
    e = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rv1 !== 1'b0) e++;
      if (c == 0) begin if (me1 !== 1'b0) e++; end
      else if (me1 !== 1'b1 || adr1 !== 11'(c - 1)) e++;
      @(posedge clk); #1;
    end
    chk("mid_rst_restart_errs", e, 0);

    // No zero-fill: ready in cycle 0, first read returns three cycles later
    chk("noinit_rst_done", id0, 1);
    chk("noinit_rst_ready", rr0, 0);
    rst_n0 = 1'b1; sel = 1'b0; cyc = 0;
    exp_q.delete(); got_q.delete(); last_pop = -1;
    for (int i = 0; i < 2048; i++) mem_ref[i] = 16'(i) ^ 16'h5A5A;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h5; rsp_ready = 1'b1;
    tick(f);
    chk("noinit_fire_c0", f, 1);
    req_valid = 1'b0;
    repeat (5) tick(f);
    chk("noinit_pop_cycle", last_pop, 3);
    chk("noinit_npops", got_q.size(), 1);
    if (got_q.size() > 0) chk("noinit_data", got_q[0], 16'h5A5F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
